sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Downstream stage of the FP-INT systolic array. On the array's completion pulse, it snapshots all N×N PE results, each a signed fixed-point accumulator plus a 5-bit exponent. It then converts each result to IEEE FP16 and streams them out one per cycle over a valid/ready handshake in PE index order. This frees the array to start its next tile while results drain.

## Interface
Parameters:
- N, 2: array dimension; N*N results per tile
- ACC_WIDTH, 32: PE accumulator width, two's complement
- FRAC_BITS, 10: fixed-point fraction bits of the accumulator
- IDX_W, 2: width of out_idx, equal to clog2(N*N), minimum 1

Ports:
- clk, input, 1: clock, rising edge
- rst, input, 1: asynchronous active-low reset
- sa_done, input, 1: array completion, level or pulse; only its rising edge is used
- exp_in, input, 5*N*N: PE k exponent at [5k+4:5k], unsigned
- acc_in, input, ACC_WIDTH*N*N: PE k accumulator at [k*ACC_WIDTH +: ACC_WIDTH], signed
- out_valid, output, 1: out_data, out_idx and out_last are valid
- out_ready, input, 1: consumer accepts the current beat
- out_data, output, 16: FP16 result
- out_idx, output, IDX_W: PE index k of the current beat
- out_last, output, 1: beat is k = N*N−1
- busy, output, 1: a snapshot is held or is draining
- overrun, output, 1: sticky flag; a completion edge was dropped

## Operation
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, overrun=0. The snapshot and pipeline registers are cleared and the done edge detector's history is cleared to 0.
- States:
  - IDLE: waits for a rising edge of sa_done (sa_done=1 and previous sample 0). On that edge it captures all of exp_in and acc_in into snapshot registers and moves to DRAIN.
  - DRAIN: a read pointer walks k = 0 … N*N−1 through a 2-stage conversion pipeline. After the handshake where out_last=1, the state returns to IDLE.
- Conversion for each element (value = acc × 2^(exp − 15 − FRAC_BITS)):
  - acc = 0 produces 0x0000.
  - Otherwise: sign = acc MSB; mag = |acc|, held in ACC_WIDTH unsigned bits so that the most negative value is handled; p = bit position of the leading one in mag.
  - Biased exponent E = p + exp − FRAC_BITS, computed signed with enough width that it cannot overflow.
  - If E ≥ 31, output sign:0x7C00 (infinity, saturation).
  - If E ≤ 0, output sign:0x0000 (flush to zero, no subnormals).
  - Otherwise the mantissa is the 10 bits below the leading one. If p < 10 they are zero-filled on the right. Lower bits are truncated (round toward zero).
- Completion edge while busy: the edge is ignored, the snapshot is unchanged, and overrun is set. overrun clears only on reset.
- Edge at the same clock as the final handshake (out_last accepted): the edge is accepted and a new snapshot is captured. busy stays 1 and the new drain starts at k=0 with no overrun.
- A level sa_done held high yields exactly one capture.

## Timing
- T = the clock edge that samples the sa_done rising edge.
- busy=1 from T+1. The first out_valid=1 with out_idx=0 appears at T+2.
- With out_ready held high: one beat per cycle, the last beat at T+1+N*N, busy=0 the cycle after the last handshake.
- Handshake: a transfer occurs on an edge where out_valid && out_ready. While out_valid && !out_ready, out_data, out_idx and out_last hold stable. The pipeline stalls without losing or duplicating any element.
- out_valid never depends combinationally on out_ready.
- Reset asserted mid-drain clears everything immediately, with no partial beats after release. The first edge after release can be captured.

## Test plan
- Conversion with N=2 and out_ready=1, inputs (acc, exp) = (1024, 15), (−1024, 15), (3072, 16), (1, 25) → out_data 0x3C00, 0xBC00, 0x4600, 0x3C00 on idx 0..3. out_last=1 only on idx 3, first beat at T+2.
- Saturation, flush and zero: (0x7FFFFFFF, 31) → 0x7C00; (−1, 0) → 0x8000; (1, 0) → 0x0000; (0, 20) → 0x0000.
- Backpressure: out_ready toggles 1,0,0,1,… → each idx appears exactly once and in order, outputs stay stable while stalled, and busy falls one cycle after the idx-3 handshake.
- Overrun: a second sa_done edge at T+3 → beats still come from the first snapshot and overrun=1. A new edge exactly at the final handshake → a new drain starts with overrun unchanged.
- Level done: sa_done held high for 20 cycles → exactly N*N beats.
- Reset mid-drain: rst=0 after beat 1 → all outputs 0 asynchronously. After release, a new edge produces a full, correct drain from idx 0.

Source files
------------

// File: rtl/sa_result_drain_if.sv
// Result stream from the systolic-array drain stage to its consumer.
// Carries one FP16 beat per handshake, tagged with its PE index and a last flag.
// A beat transfers on a clock edge where out_valid && out_ready.
//   master: drives out_valid/out_data/out_idx/out_last, samples out_ready
//   slave : samples the beat, drives out_ready
interface sa_result_drain_if #(
    parameter int IDX_W = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sa_result_drain.sv
// Purpose: snapshot N*N PE accumulators on sa_done rise, convert to FP16, stream in PE order.
// Latency: first beat valid two cycles after the edge that samples sa_done rising; then 1 beat/cycle.
// Backpressure: out_ready low freezes the whole 2-stage pipeline; the beat on the bus holds stable.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-low reset
//   sa_done       array completion; only its rising edge is used
//   exp_in        PE k exponent at [5k+4:5k], unsigned
//   acc_in        PE k accumulator at [k*ACC_WIDTH +: ACC_WIDTH], two's complement
//   drain         result stream (out_valid/out_ready/out_data/out_idx/out_last)
//   busy          a snapshot is held or still draining
//   overrun       sticky: a completion edge arrived while busy and was dropped
module sa_result_drain #(
    parameter int N         = 2,
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int IDX_W     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sa_done,
    input  logic [5*N*N-1:0]          exp_in,
    input  logic [ACC_WIDTH*N*N-1:0]  acc_in,
    sa_result_drain_if.master         drain,
    output logic                      busy,
    output logic                      overrun
);

    localparam int NN = N * N;
    // Width holding a leading-one position 0..ACC_WIDTH-1.
    localparam int PW = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
    // Biased exponent p + exp - FRAC_BITS: PW bits + 5 bits + sign, with headroom.
    localparam int EW = PW + 8;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NN - 1);
    localparam logic signed [EW-1:0] E_INF   = EW'(31);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]           state;
    logic                 done_q;

    logic [4:0]           exp_snap [NN];
    logic [ACC_WIDTH-1:0] acc_snap [NN];

    logic [IDX_W-1:0]     rd_ptr;
    logic                 rd_act;

    // Stage 1: magnitude, sign and leading-one position of one element.
    logic                 s1_vld;
    logic                 s1_sign;
    logic                 s1_zero;
    logic                 s1_last;
    logic [PW-1:0]        s1_p;
    logic [ACC_WIDTH-1:0] s1_mag;
    logic [4:0]           s1_exp;
    logic [IDX_W-1:0]     s1_idx;

    logic                 done_edge;
    logic                 adv;
    logic                 last_hs;
    logic                 capture;

    logic [ACC_WIDTH-1:0] src_acc;
    logic [ACC_WIDTH-1:0] src_mag;
    logic [4:0]           src_exp;
    logic [IDX_W-1:0]     src_idx;
    logic [PW-1:0]        src_p;

    logic signed [EW-1:0] e_big;
    logic [9:0]           mant;
    logic [15:0]          conv;

    assign done_edge = sa_done && !done_q;
    // Pipeline moves whenever the output register is empty or being consumed.
    assign adv       = !drain.out_valid || drain.out_ready;
    assign last_hs   = drain.out_valid && drain.out_ready && drain.out_last;
    // A new tile is accepted when idle, or on the very edge the previous tile's
    // final beat leaves; at that point every snapshot entry has been read.
    assign capture   = done_edge && ((state == S_IDLE) || last_hs);
    assign busy      = (state == S_DRAIN);

    // Stage-1 source. On the capture edge element 0 is taken straight from the
    // inputs so the first beat is not delayed by the snapshot write.
    always_comb begin
        src_acc = acc_snap[rd_ptr];
        src_exp = exp_snap[rd_ptr];
        src_idx = rd_ptr;
        if (capture) begin
            src_acc = acc_in[ACC_WIDTH-1:0];
            src_exp = exp_in[4:0];
            src_idx = '0;
        end
        // Unsigned magnitude: the most negative value maps to 2^(ACC_WIDTH-1).
        src_mag = src_acc[ACC_WIDTH-1] ? (~src_acc + 1'b1) : src_acc;
        src_p   = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (src_mag[i]) begin
                src_p = PW'(i);
            end
        end
    end

    // Stage 2 conversion. Shifting {mag, 10'b0} right by p puts the leading one
    // at bit 10, so bits 9:0 are the mantissa, zero-filled when p < 10 and
    // truncated (round toward zero) otherwise.
    always_comb begin
        e_big = EW'(s1_p) + EW'(s1_exp) - EW'(FRAC_BITS);
        mant  = 10'({s1_mag, 10'b0} >> s1_p);
        if (s1_zero) begin
            conv = 16'h0000;
        end else if (e_big >= E_INF) begin
            conv = {s1_sign, 15'h7C00};
        end else if (e_big[EW-1] || (e_big == '0)) begin
            conv = {s1_sign, 15'h0000};
        end else begin
            conv = {s1_sign, e_big[4:0], mant};
        end
    end

    // Control: state, edge history, sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            done_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done_q <= sa_done;
            if (done_edge && !capture) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_hs && !capture) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Snapshot registers: written only when a tile is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NN; k++) begin
                exp_snap[k] <= '0;
                acc_snap[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NN; k++) begin
                exp_snap[k] <= exp_in[k*5 +: 5];
                acc_snap[k] <= acc_in[k*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    // Read pointer. Capture already issues element 0, so the walk resumes at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            rd_act <= 1'b0;
        end else if (capture) begin
            rd_ptr <= (NN > 1) ? IDX_W'(1) : '0;
            rd_act <= (NN > 1);
        end else if (adv && rd_act) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == LAST_IDX) begin
                rd_act <= 1'b0;
            end
        end
    end

    // Stage 1 register. capture implies adv (idle, or the output is being consumed).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_last <= 1'b0;
            s1_p    <= '0;
            s1_mag  <= '0;
            s1_exp  <= '0;
            s1_idx  <= '0;
        end else if (adv) begin
            s1_vld <= capture || rd_act;
            if (capture || rd_act) begin
                s1_sign <= src_acc[ACC_WIDTH-1];
                s1_zero <= (src_acc == '0);
                s1_last <= (src_idx == LAST_IDX);
                s1_p    <= src_p;
                s1_mag  <= src_mag;
                s1_exp  <= src_exp;
                s1_idx  <= src_idx;
            end
        end
    end

    // Output register: holds the beat while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain.out_valid <= 1'b0;
            drain.out_data  <= '0;
            drain.out_idx   <= '0;
            drain.out_last  <= 1'b0;
        end else if (adv) begin
            drain.out_valid <= s1_vld;
            if (s1_vld) begin
                drain.out_data <= conv;
                drain.out_idx  <= s1_idx;
                drain.out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: directed tiles plus randomized tiles, ready patterns
// and completion-edge timing, checked every cycle against a queue-based model.
module tb_sa_result_drain;

    localparam int N     = 2;
    localparam int NN    = N * N;
    localparam int ACC   = 32;
    localparam int FRAC  = 10;
    localparam int IDX_W = 2;

    logic               clk;
    logic               rst;
    logic               sa_done;
    logic [5*NN-1:0]    exp_in;
    logic [ACC*NN-1:0]  acc_in;
    logic               busy;
    logic               overrun;

    sa_result_drain_if #(.IDX_W(IDX_W)) dif ();

    sa_result_drain #(
        .N(N), .ACC_WIDTH(ACC), .FRAC_BITS(FRAC), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .sa_done(sa_done),
        .exp_in(exp_in), .acc_in(acc_in),
        .drain(dif), .busy(busy), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FP16 value of acc * 2^(e - 15 - FRAC), truncating, no subnormals.
    function automatic logic [15:0] fp16_of(input longint acc, input int e);
        longint mag;
        longint m;
        int     p;
        int     ex;
        int     s;
        int     res;
        if (acc == 0) return 16'h0000;
        s   = (acc < 0) ? 1 : 0;
        mag = (acc < 0) ? -acc : acc;
        p   = 0;
        for (int i = 0; i < 40; i++) if ((mag >> i) != 0) p = i;
        ex  = p + e - FRAC;
        if (ex >= 31) begin
            res = s * 32768 + 16'h7C00;
        end else if (ex <= 0) begin
            res = s * 32768;
        end else begin
            m   = (p >= 10) ? (mag >> (p - 10)) : (mag << (10 - p));
            res = s * 32768 + ex * 1024 + int'(m - 1024);
        end
        return res[15:0];
    endfunction

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        last;
        int          avail;
    } beat_t;

    beat_t q[$];
    beat_t obs_q[$];

    int   cyc = 0;
    int   caps = 0;
    int   hs_count = 0;
    int   cap_edge = 0;
    int   first_vld_cyc = 0;
    int   last_hs_edge = 0;
    logic seen_first = 1'b1;
    logic exp_ovr = 1'b0;
    logic prev_done = 1'b0;
    logic held_vld = 1'b0;
    logic [15:0] held_data;
    logic [IDX_W-1:0] held_idx;
    logic held_last;
    int   rdy_mode = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Consumer ready: 0 = always 1, 1 = random, 2 = repeating 1,0,0.
    initial begin
        int pat;
        pat = 0;
        dif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       dif.out_ready = 1'b1;
                1:       dif.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    dif.out_ready = (pat == 0);
                    pat = (pat + 1) % 3;
                end
            endcase
        end
    end

    // Compare process. At each falling edge the values are those the next rising
    // edge will sample; the model is checked, then advanced across that edge.
    always @(negedge clk) begin
        logic exp_vld;
        logic hs;
        logic [31:0] a;
        if (!rst) begin
            chk("rst_out_valid", 32'(dif.out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_overrun", 32'(overrun), 0);
            q.delete();
            exp_ovr   = 1'b0;
            prev_done = 1'b0;
            held_vld  = 1'b0;
        end else begin
            exp_vld = (q.size() > 0) && (cyc >= q[0].avail);
            chk("out_valid", 32'(dif.out_valid), 32'(exp_vld));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            if (exp_vld && dif.out_valid) begin
                chk("out_idx", 32'(dif.out_idx), 32'(q[0].idx));
                chk("out_data", 32'(dif.out_data), 32'(q[0].data));
                chk("out_last", 32'(dif.out_last), 32'(q[0].last));
                if (!seen_first) begin
                    seen_first    = 1'b1;
                    first_vld_cyc = cyc;
                end
            end
            if (held_vld) begin
                chk("stall_data_stable", 32'(dif.out_data), 32'(held_data));
                chk("stall_idx_stable", 32'(dif.out_idx), 32'(held_idx));
                chk("stall_last_stable", 32'(dif.out_last), 32'(held_last));
            end
            hs        = exp_vld && dif.out_ready;
            held_vld  = exp_vld && !dif.out_ready;
            held_data = dif.out_data;
            held_idx  = dif.out_idx;
            held_last = dif.out_last;
            if (hs) begin
                obs_q.push_back('{idx: int'(dif.out_idx), data: dif.out_data,
                                  last: dif.out_last, avail: cyc});
                hs_count++;
                if (q[0].last) last_hs_edge = cyc + 1;
                void'(q.pop_front());
            end
            if (sa_done && !prev_done) begin
                if (q.size() == 0) begin
                    caps++;
                    cap_edge   = cyc + 1;
                    seen_first = 1'b0;
                    for (int k = 0; k < NN; k++) begin
                        a = acc_in[k*ACC +: ACC];
                        q.push_back('{idx: k,
                                      data: fp16_of(longint'($signed(a)), int'(exp_in[k*5 +: 5])),
                                      last: (k == NN - 1),
                                      avail: cap_edge + 1 + k});
                    end
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            prev_done = sa_done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pe(input int k, input logic [31:0] a, input logic [4:0] e);
        acc_in[k*ACC +: ACC] = a;
        exp_in[k*5 +: 5]     = e;
    endtask

    task automatic set_basic();
        set_pe(0, 32'd1024, 5'd15);
        set_pe(1, -32'sd1024, 5'd15);
        set_pe(2, 32'd3072, 5'd16);
        set_pe(3, 32'd1, 5'd25);
    endtask

    task automatic set_sat();
        set_pe(0, 32'h7FFF_FFFF, 5'd31);
        set_pe(1, 32'hFFFF_FFFF, 5'd0);
        set_pe(2, 32'd1, 5'd0);
        set_pe(3, 32'd0, 5'd20);
    endtask

    task automatic set_random();
        logic [31:0] a;
        for (int k = 0; k < NN; k++) begin
            case ($urandom_range(0, 4))
                0:       a = $urandom;
                1:       a = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 4095))
                                                         : 32'($urandom_range(0, 4095));
                2:       a = 32'd0;
                3:       a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                default: a = 32'($signed($urandom_range(0, 2)) - 1);
            endcase
            set_pe(k, a, 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic pulse();
        sa_done = 1'b1;
        tick();
        sa_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        while ((busy || q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_completes_in_budget", 32'(n < 300), 1);
        tick();
    endtask

    task automatic check_obs(input int base, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] want [4];
        want[0] = d0; want[1] = d1; want[2] = d2; want[3] = d3;
        chk("obs_beat_count", 32'(obs_q.size() >= base + NN), 1);
        for (int k = 0; k < NN; k++) begin
            if (obs_q.size() > base + k) begin
                chk("obs_idx", 32'(obs_q[base+k].idx), 32'(k));
                chk("obs_data_literal", 32'(obs_q[base+k].data), 32'(want[k]));
                chk("obs_last", 32'(obs_q[base+k].last), 32'(k == NN - 1));
            end
        end
    endtask

    initial begin
        int c0;
        int n;
        rst = 1'b0;
        sa_done = 1'b0;
        acc_in = '0;
        exp_in = '0;
        rdy_mode = 0;
        repeat (3) tick();

        // Reset values
        chk("reset_out_valid", 32'(dif.out_valid), 0);
        chk("reset_out_data", 32'(dif.out_data), 0);
        chk("reset_out_idx", 32'(dif.out_idx), 0);
        chk("reset_out_last", 32'(dif.out_last), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_overrun", 32'(overrun), 0);

        // Pin the model to hand-computed values
        chk("model_1024_e15", 32'(fp16_of(1024, 15)), 32'h3C00);
        chk("model_3072_e16", 32'(fp16_of(3072, 16)), 32'h4600);
        chk("model_sat", 32'(fp16_of(64'h7FFF_FFFF, 31)), 32'h7C00);
        chk("model_neg_flush", 32'(fp16_of(-1, 0)), 32'h8000);
        chk("model_min_neg", 32'(fp16_of(-64'sd2147483648, 0)), 32'hD400);

        rst = 1'b1;
        tick();

        // Basic conversion, latency and last-beat timing
        set_basic();
        obs_q.delete();
        pulse();
        wait_idle();
        check_obs(0, 16'h3C00, 16'hBC00, 16'h4600, 16'h3C00);
        chk("first_beat_one_cycle_after_T", 32'(first_vld_cyc - cap_edge), 1);
        chk("last_handshake_edge_T+1+NN", 32'(last_hs_edge - cap_edge), 32'(1 + NN));

        // Saturation/flush/zero tile, then a new edge exactly on its final handshake
        set_sat();
        obs_q.delete();
        c0 = caps;
        pulse();
        set_basic();
        repeat (NN) tick();
        pulse();
        wait_idle();
        check_obs(0, 16'h7C00, 16'h8000, 16'h0000, 16'h0000);
        check_obs(NN, 16'h3C00, 16'hBC00, 16'h4600, 16'h3C00);
        chk("overlap_edge_captured", 32'(caps - c0), 2);
        chk("overlap_no_overrun", 32'(overrun), 0);

        // Backpressure 1,0,0,1,...
        rdy_mode = 2;
        set_random();
        obs_q.delete();
        pulse();
        wait_idle();
        chk("bp_beat_count", 32'(obs_q.size()), 32'(NN));
        for (int k = 0; k < NN && k < obs_q.size(); k++) chk("bp_idx_order", 32'(obs_q[k].idx), 32'(k));

        // Overrun: second edge at T+3 with different inputs is ignored
        rdy_mode = 0;
        set_random();
        obs_q.delete();
        pulse();
        tick();
        set_random();
        pulse();
        wait_idle();
        chk("overrun_set", 32'(overrun), 1);
        chk("overrun_beat_count", 32'(obs_q.size()), 32'(NN));

        // Level sa_done held high for 20 cycles
        rdy_mode = 1;
        set_random();
        c0 = hs_count;
        sa_done = 1'b1;
        repeat (20) tick();
        sa_done = 1'b0;
        wait_idle();
        chk("level_done_beats", 32'(hs_count - c0), 32'(NN));

        // Reset mid-drain after beat 1
        rdy_mode = 0;
        set_random();
        c0 = hs_count;
        pulse();
        n = 0;
        while (hs_count < c0 + 2 && n < 50) begin
            tick();
            n++;
        end
        chk("reached_beat1", 32'(n < 50), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(dif.out_valid), 0);
        chk("async_rst_out_data", 32'(dif.out_data), 0);
        chk("async_rst_out_idx", 32'(dif.out_idx), 0);
        chk("async_rst_out_last", 32'(dif.out_last), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_overrun", 32'(overrun), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        set_basic();
        obs_q.delete();
        pulse();
        wait_idle();
        check_obs(0, 16'h3C00, 16'hBC00, 16'h4600, 16'h3C00);

        // Randomized tiles, ready patterns and edge timing
        for (int t = 0; t < 40; t++) begin
            rdy_mode = $urandom_range(0, 2);
            set_random();
            repeat ($urandom_range(0, 3)) tick();
            pulse();
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 8)) tick();
                set_random();
                pulse();
            end
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
